// File: rtl/prog_load_ctrl_pkg.sv
// Shared definitions for the program loader: FSM state encoding and word geometry.
// Optional build macro used by the loader: PROG_CHECKSUM_EN.
package prog_load_defs;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_FIRST = 2'd1,
        ST_RECV       = 2'd2,
        ST_DONE       = 2'd3
    } state_e;

    localparam int BYTES_PER_WORD = 4;
    localparam int BIDX_W         = $clog2(BYTES_PER_WORD);

    // Little-endian placement: byte k lands in bits [8k+7:8k].
    function automatic logic [31:0] merge_byte(input logic [31:0]       word,
                                               input logic [BIDX_W-1:0] idx,
                                               input logic [7:0]        b);
        logic [31:0] merged;
        merged             = word;
        merged[8*idx +: 8] = b;
        return merged;
    endfunction

endpackage

// File: rtl/prog_load_ctrl_if.sv
// Byte-stream input, memory write port and status bundle of the program loader.
// master = loader side, slave = surrounding system (UART RX, memory mux, CPU).
interface prog_load_ctrl_if #(
    parameter int ADDR_W = 14
);
    logic              start_load;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              cpu_hold;
    logic              mem_sel;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_rst_req;
    logic              load_done;
    logic              load_err;
    logic [ADDR_W:0]   word_count;
    logic [31:0]       checksum;

    modport master (
        input  start_load, byte_valid, byte_data,
        output cpu_hold, mem_sel, mem_we, mem_addr, mem_wdata,
        output cpu_rst_req, load_done, load_err, word_count, checksum
    );

    modport slave (
        output start_load, byte_valid, byte_data,
        input  cpu_hold, mem_sel, mem_we, mem_addr, mem_wdata,
        input  cpu_rst_req, load_done, load_err, word_count, checksum
    );
endinterface

// File: rtl/prog_load_ctrl_load_timeout_cnt.sv
// Reloadable idle-timeout down-counter for the program loader.
// zero_o flags the cycle in which the counter runs out (TIMEOUT_CYC >= 2).
module load_timeout_cnt #(
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic clock,
    input  logic reset,
    input  logic load_i,
    input  logic en_i,
    output logic zero_o
);
    localparam int            CW     = $clog2(TIMEOUT_CYC + 1);
    // The cycle that carries the byte is the first of the TIMEOUT_CYC idle cycles.
    localparam logic [CW-1:0] RELOAD = CW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] ONE    = CW'(1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = RELOAD;
        end else if (en_i && cnt_q != '0) begin
            cnt_d = cnt_q - ONE;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = en_i && !load_i && (cnt_q <= ONE);

endmodule

// File: rtl/prog_load_ctrl.sv
// Program download sequencer: freezes the CPU, packs UART bytes into words and writes them
// to sequential word addresses. Optional running checksum under `PROG_CHECKSUM_EN.
module prog_load_ctrl
    import prog_load_defs::*;
#(
    parameter int ADDR_W      = 14,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic             clock,
    input  logic             reset,
    prog_load_ctrl_if.master bus
);
    localparam logic [ADDR_W:0]   ONE_W     = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   CAPACITY  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   LAST_SLOT = CAPACITY - ONE_W;
    localparam logic [BIDX_W-1:0] LAST_IDX  = BIDX_W'(BYTES_PER_WORD - 1);
    localparam logic [BIDX_W-1:0] ONE_IDX   = BIDX_W'(1);

    state_e              state_q, state_d;
    logic [BIDX_W-1:0]   idx_q, idx_d;
    logic [31:0]         buf_q, buf_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                we_q, we_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

    logic accept, full, tmo_en, tmo_zero;
    logic hold_c, rst_req_c;

    load_timeout_cnt #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_tmo (
        .clock  (clock),
        .reset  (reset),
        .load_i (accept),
        .en_i   (tmo_en),
        .zero_o (tmo_zero)
    );

    // A write still in flight already owns the slot at count_q.
    assign full = (count_q == CAPACITY) || (we_q && count_q == LAST_SLOT);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        buf_d     = buf_q;
        wdata_d   = wdata_q;
        addr_d    = addr_q;
        we_d      = 1'b0;
        count_d   = count_q;
        done_d    = done_q;
        err_d     = err_q;
        accept    = 1'b0;
        tmo_en    = 1'b0;
        hold_c    = 1'b1;
        rst_req_c = 1'b0;

        if (we_q) begin
            count_d = count_q + ONE_W;
        end

        unique case (state_q)
            ST_IDLE: begin
                hold_c = 1'b0;
                if (bus.start_load) begin
                    state_d = ST_WAIT_FIRST;
                    count_d = '0;
                    idx_d   = '0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            ST_WAIT_FIRST: begin
                if (bus.byte_valid) begin
                    accept  = 1'b1;
                    state_d = ST_RECV;
                end
            end
            ST_RECV: begin
                tmo_en = 1'b1;
                if (bus.byte_valid) begin
                    accept = 1'b1;
                end else if (tmo_zero) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                rst_req_c = 1'b1;
                done_d    = 1'b1;
                idx_d     = '0;
                state_d   = ST_IDLE;
                if (idx_q != '0) begin
                    err_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            if (full) begin
                err_d = 1'b1;
            end else if (idx_q == LAST_IDX) begin
                wdata_d = merge_byte(buf_q, idx_q, bus.byte_data);
                addr_d  = count_q[ADDR_W-1:0];
                we_d    = 1'b1;
                idx_d   = '0;
            end else begin
                buf_d = merge_byte(buf_q, idx_q, bus.byte_data);
                idx_d = idx_q + ONE_IDX;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            buf_q   <= '0;
            wdata_q <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            count_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            buf_q   <= buf_d;
            wdata_q <= wdata_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            count_q <= count_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

`ifdef PROG_CHECKSUM_EN
    logic [31:0] sum_q, sum_d;
    logic        sum_clr;

    assign sum_clr = (state_q == ST_IDLE) && bus.start_load;

    always_comb begin
        sum_d = sum_q;
        if (sum_clr) begin
            sum_d = '0;
        end else if (we_q) begin
            sum_d = sum_q + wdata_q;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign bus.checksum = sum_q;
`else
    assign bus.checksum = '0;
`endif

    assign bus.cpu_hold    = hold_c;
    assign bus.mem_sel     = hold_c;
    assign bus.mem_we      = we_q;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_wdata   = wdata_q;
    assign bus.cpu_rst_req = rst_req_c;
    assign bus.load_done   = done_q;
    assign bus.load_err    = err_q;
    assign bus.word_count  = count_q;

endmodule
